// File: rtl/sel_counter_table_pkg.sv
// Shared branch-predictor definitions: selector table defaults and sweep FSM states.
package sel_counter_table_pkg;

  localparam int unsigned CtrWDefault = 2;
  localparam int unsigned IdxWDefault = 6;

  // INIT sweeps the table to the reset value; RUN serves lookups and updates.
  typedef enum logic {
    StInit,
    StRun
  } tbl_state_e;

  // Reset value: one below the midpoint, i.e. weakly prefer predictor 1.
  function automatic int unsigned init_ctr(int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_ctr_update.sv
// Combinational saturating up/down step for one selector counter.
module sat_ctr_update #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             p1_correct_i,
  input  logic             p2_correct_i,
  output logic [CTR_W-1:0] ctr_o,
  output logic             changed_o
);

  // P2-only win counts up, P1-only win counts down, ties hold; both ends saturate.
  always_comb begin
    ctr_o = ctr_i;
    if (p2_correct_i && !p1_correct_i && (ctr_i != '1)) begin
      ctr_o = ctr_i + CTR_W'(1);
    end else if (p1_correct_i && !p2_correct_i && (ctr_i != '0)) begin
      ctr_o = ctr_i - CTR_W'(1);
    end
    changed_o = (ctr_o != ctr_i);
  end

endmodule

// File: rtl/sel_counter_table.sv
// Tournament selector table: one saturating counter per index choosing between
// predictor 1 and predictor 2, with a post-reset initialisation sweep.
module sel_counter_table
  import sel_counter_table_pkg::*;
#(
  parameter int unsigned CTR_W = CtrWDefault,
  parameter int unsigned IDX_W = IdxWDefault,
  parameter int unsigned INIT  = init_ctr(CTR_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_valid,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             p1_correct,
  input  logic             p2_correct,
  output logic             rd_vld_o,
  output logic             rd_sel,
  output logic [CTR_W-1:0] rd_ctr,
  output logic             wr_en,
  output logic             init_busy
);

  localparam int unsigned      DEPTH   = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] InitVal = CTR_W'(INIT);

  logic [CTR_W-1:0] table_q [DEPTH];

  tbl_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             rd_vld_q, rd_vld_d;
  logic             rd_sel_q, rd_sel_d;
  logic [CTR_W-1:0] rd_ctr_q, rd_ctr_d;
  logic             wr_en_q, wr_en_d;

  logic [CTR_W-1:0] upd_cur, upd_nxt, rd_val;
  logic             upd_changed, upd_fire;

  assign upd_cur  = table_q[upd_idx];
  assign upd_fire = upd_valid && (state_q == StRun);

  sat_ctr_update #(
    .CTR_W(CTR_W)
  ) u_sat_ctr_update (
    .ctr_i       (upd_cur),
    .p1_correct_i(p1_correct),
    .p2_correct_i(p2_correct),
    .ctr_o       (upd_nxt),
    .changed_o   (upd_changed)
  );

  // Sweep FSM: one entry per cycle in INIT, leave after the last entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StInit: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (&ptr_q) begin
          state_d = StRun;
          ptr_d   = '0;
        end
      end
      StRun: begin
        ptr_d = '0;
      end
    endcase
  end

  // Lookup result with write-first bypass; INIT answers with the reset value.
  always_comb begin
    rd_val = table_q[rd_idx];
    if (state_q == StInit) begin
      rd_val = InitVal;
    end else if (upd_fire && (upd_idx == rd_idx)) begin
      rd_val = upd_nxt;
    end
    rd_vld_d = rd_valid;
    rd_ctr_d = rd_valid ? rd_val : rd_ctr_q;
    rd_sel_d = rd_valid ? rd_val[CTR_W-1] : rd_sel_q;
    wr_en_d  = upd_fire && upd_changed;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StInit;
      ptr_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_ctr_q <= '0;
      wr_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rd_vld_q <= rd_vld_d;
      rd_sel_q <= rd_sel_d;
      rd_ctr_q <= rd_ctr_d;
      wr_en_q  <= wr_en_d;
    end
  end

  // Table storage: sweep writes in INIT, counter updates in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StInit) begin
        table_q[ptr_q] <= InitVal;
      end else if (upd_fire) begin
        table_q[upd_idx] <= upd_nxt;
      end
    end
  end

  assign rd_vld_o  = rd_vld_q;
  assign rd_sel    = rd_sel_q;
  assign rd_ctr    = rd_ctr_q;
  assign wr_en     = wr_en_q;
  assign init_busy = (state_q == StInit);

endmodule

// File: tb/tb_sel_counter_table.sv
// Scoreboard bench: two tables (CTR_W=2 and CTR_W=3) share the same stimulus and
// are checked against an array-based reference model.
module tb_sel_counter_table;

  localparam int Depth = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rd_valid, upd_valid, p1_correct, p2_correct;
  logic [5:0] rd_idx, upd_idx;

  logic       rd_vld0, rd_sel0, wr_en0, busy0;
  logic [1:0] ctr0;
  logic       rd_vld1, rd_sel1, wr_en1, busy1;
  logic [2:0] ctr1;

  sel_counter_table #(.CTR_W(2), .IDX_W(6)) u_dut0 (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .p1_correct(p1_correct),
    .p2_correct(p2_correct), .rd_vld_o(rd_vld0), .rd_sel(rd_sel0), .rd_ctr(ctr0),
    .wr_en(wr_en0), .init_busy(busy0)
  );

  sel_counter_table #(.CTR_W(3), .IDX_W(6)) u_dut1 (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .p1_correct(p1_correct),
    .p2_correct(p2_correct), .rd_vld_o(rd_vld1), .rd_sel(rd_sel1), .rd_ctr(ctr1),
    .wr_en(wr_en1), .init_busy(busy1)
  );

  typedef struct {bit rst; bit rd; bit wr; bit busy;} cyc_t;
  typedef struct {int ctr; bit sel;} rd_t;

  cyc_t cq0[$], cq1[$];
  rd_t  rq0[$], rq1[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: counter values and remaining INIT cycles per instance.
  int tbl[2][Depth];
  int init_left[2];
  int ctr_w[2] = '{2, 3};

  function automatic int max_val(int k);
    return (1 << ctr_w[k]) - 1;
  endfunction

  function automatic int init_val(int k);
    return (1 << (ctr_w[k] - 1)) - 1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance model k across one clock edge using the currently driven inputs.
  task automatic model(input int k, output cyc_t c, output rd_t r);
    int old_v, new_v;
    c = '{rst: reset, rd: 1'b0, wr: 1'b0, busy: 1'b1};
    r = '{ctr: 0, sel: 1'b0};
    if (reset) begin
      for (int i = 0; i < Depth; i++) tbl[k][i] = init_val(k);
      init_left[k] = Depth;
      return;
    end
    if (init_left[k] > 0) begin
      init_left[k]--;
      if (rd_valid) begin
        c.rd  = 1'b1;
        r.ctr = init_val(k);
      end
    end else begin
      if (upd_valid) begin
        old_v = tbl[k][upd_idx];
        new_v = old_v;
        if (p2_correct && !p1_correct) new_v = (old_v < max_val(k)) ? old_v + 1 : old_v;
        else if (p1_correct && !p2_correct) new_v = (old_v > 0) ? old_v - 1 : 0;
        c.wr = (new_v != old_v);
        tbl[k][upd_idx] = new_v;
      end
      if (rd_valid) begin
        c.rd  = 1'b1;
        r.ctr = tbl[k][rd_idx];
      end
    end
    r.sel  = (r.ctr >= (1 << (ctr_w[k] - 1)));
    c.busy = (init_left[k] > 0);
  endtask

  task automatic step(bit rst, bit rv, int ri, bit uv, int ui, bit p1, bit p2);
    cyc_t c;
    rd_t  r;
    @(negedge clk);
    reset      = rst;
    rd_valid   = rv;
    rd_idx     = 6'(ri);
    upd_valid  = uv;
    upd_idx    = 6'(ui);
    p1_correct = p1;
    p2_correct = p2;
    model(0, c, r);
    cq0.push_back(c);
    if (c.rd) rq0.push_back(r);
    model(1, c, r);
    cq1.push_back(c);
    if (c.rd) rq1.push_back(r);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(int ui, bit p1, bit p2);
    step(0, 0, 0, 1, ui, p1, p2);
  endtask

  task automatic look(int ri);
    step(0, 1, ri, 0, 0, 0, 0);
  endtask

  // Monitor: per-cycle control checks, lookup results popped when rd_vld_o rises.
  initial begin
    cyc_t c;
    rd_t  r;
    forever begin
      @(posedge clk);
      #1;
      if (cq0.size() > 0) begin
        c = cq0.pop_front();
        chk("rd_vld_o w2", rd_vld0, c.rd);
        chk("wr_en w2", wr_en0, c.wr);
        chk("init_busy w2", busy0, c.busy);
        if (c.rst) begin
          chk("reset rd_ctr w2", ctr0, 0);
          chk("reset rd_sel w2", rd_sel0, 0);
        end
      end
      if (rd_vld0 === 1'b1) begin
        if (rq0.size() == 0) chk("unexpected rd w2", rd_vld0, 0);
        else begin
          r = rq0.pop_front();
          chk("rd_ctr w2", ctr0, r.ctr);
          chk("rd_sel w2", rd_sel0, r.sel);
        end
      end
      if (cq1.size() > 0) begin
        c = cq1.pop_front();
        chk("rd_vld_o w3", rd_vld1, c.rd);
        chk("wr_en w3", wr_en1, c.wr);
        chk("init_busy w3", busy1, c.busy);
        if (c.rst) begin
          chk("reset rd_ctr w3", ctr1, 0);
          chk("reset rd_sel w3", rd_sel1, 0);
        end
      end
      if (rd_vld1 === 1'b1) begin
        if (rq1.size() == 0) chk("unexpected rd w3", rd_vld1, 0);
        else begin
          r = rq1.pop_front();
          chk("rd_ctr w3", ctr1, r.ctr);
          chk("rd_sel w3", rd_sel1, r.sel);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; rd_valid = 1'b0; upd_valid = 1'b0;
    p1_correct = 1'b0; p2_correct = 1'b0; rd_idx = '0; upd_idx = '0;

    // Reset, full idle sweep, then read the last entry.
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    repeat (Depth) idle();
    look(63);

    // Count up on idx 5 through saturation, then read back.
    repeat (4) upd(5, 0, 1);
    look(5);

    // Tie holds, then P1 wins count down.
    upd(5, 1, 1);
    repeat (3) upd(5, 1, 0);
    look(5);

    // Same-cycle update and lookup on idx 9 (bypass).
    step(0, 1, 9, 1, 9, 0, 1);
    idle();

    // Drive idx 5 into both saturation ends for either width.
    repeat (8) upd(5, 0, 1);
    look(5);
    repeat (9) upd(5, 1, 0);
    look(5);

    // Back-to-back updates on different and same indices with lookups interleaved.
    step(0, 1, 3, 1, 3, 0, 1);
    step(0, 1, 3, 1, 3, 0, 1);
    step(0, 1, 4, 1, 3, 1, 0);

    // Modify idx 7, reset in RUN, reset again mid-INIT, update ignored during INIT.
    upd(7, 0, 1);
    look(7);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    repeat (20) idle();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < Depth; i++) begin
      if (i == 10) step(0, 1, 7, 1, 20, 0, 1);
      else idle();
    end
    look(7);
    look(20);

    // Randomised traffic on a few hot indices, with an occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) step(1, 0, 0, 0, 0, 0, 0);
      else step(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) idle();
    @(posedge clk);
    #2;
    chk("pending rd w2", rq0.size(), 0);
    chk("pending rd w3", rq1.size(), 0);
    chk("pending cyc w2", cq0.size(), 0);
    chk("pending cyc w3", cq1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sel_counter_table.md
SEL_COUNTER_TABLE -- requirements
Module: sel_counter_table

Interface
REQ-001 Parameter CTR_W, default 2, width in bits of each saturating selector counter (legal 2..4).
REQ-002 Parameter IDX_W, default 6, index width; the table SHALL hold DEPTH = 2^IDX_W counters.
REQ-003 Parameter INIT, default 2^(CTR_W-1)-1 (weakly prefer P1), counter value loaded at reset.
REQ-004 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rd_valid  input  1  lookup request this cycle.
REQ-007 rd_idx  input  IDX_W  lookup index.
REQ-008 upd_valid  input  1  resolved-branch update this cycle.
REQ-009 upd_idx  input  IDX_W  update index.
REQ-010 p1_correct  input  1  predictor 1 was correct for the resolved branch.
REQ-011 p2_correct  input  1  predictor 2 was correct for the resolved branch.
REQ-012 rd_vld_o  output  1  lookup result valid; rd_valid delayed one cycle.
REQ-013 rd_sel  output  1  0 selects P1, 1 selects P2.
REQ-014 rd_ctr  output  CTR_W  counter value behind rd_sel.
REQ-015 wr_en  output  1  registered; 1 when the last accepted update changed the counter.
REQ-016 init_busy  output  1  table initialisation sweep in progress.

Function
REQ-017 rd_sel SHALL be 1 when the counter value is >= 2^(CTR_W-1), else 0.
REQ-018 Lookups SHALL have exactly one cycle latency: rd_vld_o, rd_sel and rd_ctr register the result of the rd_idx sampled on the previous edge.
REQ-019 On an accepted update, p2_correct=1 and p1_correct=0 SHALL increment the counter, saturating at 2^CTR_W-1.
REQ-020 On an accepted update, p1_correct=1 and p2_correct=0 SHALL decrement the counter, saturating at 0.
REQ-021 When p1_correct equals p2_correct, the update SHALL leave the counter unchanged.
REQ-022 wr_en SHALL be 1 on the cycle after an accepted update that changed the counter, and 0 otherwise (no update, both-equal case, or saturation hold).
REQ-023 An update and a lookup to the same index in the same cycle SHALL return the post-update value (write-first bypass).
REQ-024 Updates to different indices SHALL be independent; consecutive cycles to the same index SHALL accumulate with no lost update.
REQ-025 The table SHALL have two states, INIT and RUN.
REQ-026 INIT SHALL write INIT to entry 0, 1, ... DEPTH-1, one entry per cycle, then move to RUN, so INIT lasts DEPTH cycles after reset deasserts.
REQ-027 In INIT, updates SHALL be ignored (wr_en=0), and lookups SHALL return rd_vld_o=1 with rd_ctr=INIT.
REQ-028 init_busy SHALL be 1 exactly while the state is INIT.

Reset
REQ-029 While reset is high: state=INIT, sweep pointer=0, rd_vld_o=0, rd_sel=0, rd_ctr=0, wr_en=0, init_busy=1.
REQ-030 Reset asserted during INIT or RUN SHALL restart the sweep from entry 0 on the first cycle reset is low.

Structure
REQ-031 CTR_W/IDX_W defaults, INIT derivation and the INIT/RUN state encoding SHALL live in the shared branch-predictor header.
REQ-032 The saturating up/down update SHALL be a sub-module sat_ctr_update (combinational, CTR_W-parametrised); the table, bypass and sweep FSM SHALL stay in sel_counter_table.

Verification
REQ-033 Reset, then hold idle DEPTH=64 cycles -> init_busy high exactly 64 cycles; lookup of idx 63 afterwards -> rd_ctr=1, rd_sel=0.
REQ-034 idx 5, four updates with p2_correct=1, p1_correct=0 (CTR_W=2) -> wr_en 1,1,0,0 (counter 2,3,3,3); lookup -> rd_ctr=3, rd_sel=1.
REQ-035 From counter 3, an update with p1_correct=p2_correct=1 -> wr_en=0, counter stays 3; three P1-wins -> counter 0, wr_en 1,1,1.
REQ-036 Same-cycle update (P2-win) and lookup on idx 9 holding 1 -> next cycle rd_ctr=2, rd_sel=1.
REQ-037 Update issued on cycle 10 of INIT -> ignored; after INIT that entry reads INIT.
REQ-038 Reset pulsed in RUN after modifying idx 7 -> full 64-cycle sweep again, idx 7 reads INIT; repeat the counter tests with CTR_W=3 (saturation at 7/0, threshold 4).
